// File: rtl/controlador_lavagem_if.sv
// Signal bundle between the wash sequencer and its environment (sensors,
// actuators and the spin module handshake).
interface controlador_lavagem_if;
  logic       start;
  logic       porta_aberta;
  logic       nivel_cheio;
  logic       nivel_vazio;
  logic       centrifugacao_ativa;
  logic       valvula_entrada;
  logic       motor_lavar;
  logic       bomba_saida;
  logic       start_centrifugacao;
  logic [2:0] fase;
  logic       concluido;
  logic       erro;

  // Environment side: drives sensors and start, observes actuators
  modport master (
    output start, porta_aberta, nivel_cheio, nivel_vazio, centrifugacao_ativa,
    input  valvula_entrada, motor_lavar, bomba_saida, start_centrifugacao, fase, concluido, erro
  );

  // Sequencer side
  modport slave (
    input  start, porta_aberta, nivel_cheio, nivel_vazio, centrifugacao_ativa,
    output valvula_entrada, motor_lavar, bomba_saida, start_centrifugacao, fase, concluido, erro
  );
endinterface

// File: rtl/controlador_lavagem.sv
// Wash-cycle sequencer: fill -> wash -> drain, NUM_ENXAGUES x (fill -> rinse -> drain),
// then spin. Handles door-open pause/resume, fill/drain/spin timeouts and a sticky error.
module controlador_lavagem #(
  parameter int unsigned TEMPO_LAVAGEM   = 20,
  parameter int unsigned TEMPO_ENXAGUE   = 10,
  parameter int unsigned NUM_ENXAGUES    = 2,
  parameter int unsigned TIMEOUT_NIVEL   = 50,
  parameter int unsigned TIMEOUT_CENTRIF = 15
) (
  input logic                   clock,
  input logic                   reset_n,
  controlador_lavagem_if.slave  bus
);

  typedef enum logic [2:0] {
    Ocioso      = 3'd0,
    Encher      = 3'd1,
    Lavar       = 3'd2,
    Enxaguar    = 3'd3,
    Esvaziar    = 3'd4,
    Centrifugar = 3'd5,
    Pausa       = 3'd6,
    Erro        = 3'd7
  } estado_t;

  // Last timer value of each phase (timer counts from 0 on entry)
  localparam logic [15:0] LimLavagem = 16'(TEMPO_LAVAGEM - 1);
  localparam logic [15:0] LimEnxague = 16'(TEMPO_ENXAGUE - 1);
  localparam logic [15:0] LimNivel   = 16'(TIMEOUT_NIVEL - 1);
  localparam logic [15:0] LimCentrif = 16'(TIMEOUT_CENTRIF - 1);
  localparam logic [2:0]  NumEnx     = 3'(NUM_ENXAGUES);

  estado_t     estado, estado_prox;
  estado_t     salvo, salvo_prox;
  logic [15:0] timer, timer_prox;
  logic [2:0]  enxagues, enxagues_prox;
  logic        visto, visto_prox;
  logic        start_ant;
  logic        start_edge;
  logic        concluido_prox;
  logic        pausar;

  assign start_edge = bus.start & ~start_ant;
  // Door only pauses an active washing phase
  assign pausar = bus.porta_aberta &&
                  (estado inside {Encher, Lavar, Enxaguar, Esvaziar, Centrifugar});

  // Next-state, saved-state, rinse counter, spin flag and phase timer
  always_comb begin
    estado_prox    = estado;
    salvo_prox     = salvo;
    enxagues_prox  = enxagues;
    visto_prox     = visto;
    concluido_prox = 1'b0;

    unique case (estado)
      Ocioso: begin
        if (start_edge && !bus.porta_aberta) begin
          estado_prox   = Encher;
          enxagues_prox = '0;
        end
      end
      Encher: begin
        if (timer >= LimNivel) begin
          estado_prox = Erro;
        end else if (bus.nivel_cheio) begin
          estado_prox = (enxagues == '0) ? Lavar : Enxaguar;
        end
      end
      Lavar: begin
        if (timer >= LimLavagem) estado_prox = Esvaziar;
      end
      Enxaguar: begin
        if (timer >= LimEnxague) estado_prox = Esvaziar;
      end
      Esvaziar: begin
        if (timer >= LimNivel) begin
          estado_prox = Erro;
        end else if (bus.nivel_vazio) begin
          if (enxagues < NumEnx) begin
            enxagues_prox = enxagues + 3'd1;
            estado_prox   = Encher;
          end else begin
            estado_prox = Centrifugar;
            visto_prox  = 1'b0;
          end
        end
      end
      Centrifugar: begin
        if (timer >= LimCentrif) begin
          estado_prox = Erro;
        end else if (visto && !bus.centrifugacao_ativa) begin
          estado_prox    = Ocioso;
          concluido_prox = 1'b1;
        end else if (bus.centrifugacao_ativa) begin
          visto_prox = 1'b1;
        end
      end
      Pausa: begin
        if (start_edge && !bus.porta_aberta) begin
          estado_prox = salvo;
          // Spin module restarted from scratch, so the burst must be seen again
          if (salvo == Centrifugar) visto_prox = 1'b0;
        end
      end
      Erro: estado_prox = Erro;
    endcase

    // Door has top priority over every timeout/completion decision above
    if (pausar) begin
      estado_prox    = Pausa;
      salvo_prox     = estado;
      enxagues_prox  = enxagues;
      visto_prox     = visto;
      concluido_prox = 1'b0;
    end

    // Pausing still counts the cycle just spent, so resumed phases keep their total length
    if (estado == Ocioso || estado == Erro) begin
      timer_prox = '0;
    end else if (estado == Pausa) begin
      timer_prox = (estado_prox == Centrifugar) ? '0 : timer;
    end else if (estado_prox == estado || estado_prox == Pausa) begin
      timer_prox = timer + 16'd1;
    end else begin
      timer_prox = '0;
    end
  end

  // State registers and Moore outputs registered from the next state
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      estado                  <= Ocioso;
      salvo                   <= Ocioso;
      timer                   <= '0;
      enxagues                <= '0;
      visto                   <= 1'b0;
      start_ant               <= 1'b0;
      bus.fase                <= 3'd0;
      bus.valvula_entrada     <= 1'b0;
      bus.motor_lavar         <= 1'b0;
      bus.bomba_saida         <= 1'b0;
      bus.start_centrifugacao <= 1'b0;
      bus.concluido           <= 1'b0;
      bus.erro                <= 1'b0;
    end else begin
      estado                  <= estado_prox;
      salvo                   <= salvo_prox;
      timer                   <= timer_prox;
      enxagues                <= enxagues_prox;
      visto                   <= visto_prox;
      start_ant               <= bus.start;
      bus.fase                <= estado_prox;
      bus.valvula_entrada     <= (estado_prox == Encher);
      bus.motor_lavar         <= (estado_prox == Lavar) || (estado_prox == Enxaguar);
      bus.bomba_saida         <= (estado_prox == Esvaziar);
      bus.start_centrifugacao <= (estado_prox == Centrifugar);
      bus.concluido           <= concluido_prox;
      bus.erro                <= (estado_prox == Erro);
    end
  end

endmodule

// File: tb/tb_controlador_lavagem.sv
// Bench for controlador_lavagem: cycle table, directed pause/timeout/reset
// sequences and randomized full runs checked against a phase-length model.
module tb_controlador_lavagem;
  localparam int TL = 20;
  localparam int TE = 10;
  localparam int NE = 2;
  localparam int TN = 50;
  localparam int TC = 15;
  // Spin model: 1 cycle before ativa, 5 cycles active, 1 cycle for the fall to be seen
  localparam int SpinLen = 1 + 5 + 1;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  controlador_lavagem_if bus ();

  controlador_lavagem #(
    .TEMPO_LAVAGEM  (TL),
    .TEMPO_ENXAGUE  (TE),
    .NUM_ENXAGUES   (NE),
    .TIMEOUT_NIVEL  (TN),
    .TIMEOUT_CENTRIF(TC)
  ) dut (
    .clock  (clock),
    .reset_n(reset_n),
    .bus    (bus.slave)
  );

  int n_checks = 0;
  int n_pass = 0;

  // Plant state
  bit plant_on;
  bit stuck;
  int d_fill[8];
  int d_drain[8];
  int fase_ant, fase_cnt, fill_i, drain_i, cur_df, cur_dv, sc_cnt;
  int motor_cyc, concl_cnt, ativa_cyc;

  // Model expectations
  int exp_code[$];
  int exp_len[$];
  int exp_motor, exp_concl, exp_erro;

  typedef struct {
    logic       start;
    logic       porta;
    logic       cheio;
    logic [8:0] saida;  // {fase, valvula, motor, bomba, start_centrif, concluido, erro}
  } linha_t;
  linha_t tab[14];

  task automatic check(input string nome, input int got, input int expv);
    n_checks++;
    if (got == expv) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nome, got, expv);
  endtask

  function automatic logic [8:0] saidas();
    return {bus.fase, bus.valvula_entrada, bus.motor_lavar, bus.bomba_saida,
            bus.start_centrifugacao, bus.concluido, bus.erro};
  endfunction

  task automatic limpa();
    bus.start = 0; bus.porta_aberta = 0; bus.nivel_cheio = 0;
    bus.nivel_vazio = 0; bus.centrifugacao_ativa = 0;
    fase_ant = 0; fase_cnt = 0; fill_i = 0; drain_i = 0; cur_df = 0; cur_dv = 0;
    sc_cnt = 0; motor_cyc = 0; concl_cnt = 0; ativa_cyc = 0;
  endtask

  task automatic reinicia();
    @(negedge clock);
    reset_n = 1'b0;
    limpa();
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
  endtask

  task automatic atrasos(input int df, input int dv, input bit trava);
    for (int i = 0; i < 8; i++) begin
      d_fill[i] = df;
      d_drain[i] = dv;
    end
    stuck = trava;
  endtask

  // One clock: sample outputs after the edge, then update the plant's inputs
  task automatic ciclo();
    int f;
    @(posedge clock);
    #1;
    f = int'(bus.fase);
    if (f != fase_ant) begin
      fase_cnt = 0;
      if (f == 1) begin cur_df = d_fill[fill_i % 8]; fill_i++; end
      if (f == 4) begin cur_dv = d_drain[drain_i % 8]; drain_i++; end
    end else begin
      fase_cnt++;
    end
    fase_ant = f;
    motor_cyc += int'(bus.motor_lavar);
    concl_cnt += int'(bus.concluido);
    if (plant_on) begin
      bus.nivel_cheio = (f == 1) && (fase_cnt >= cur_df);
      bus.nivel_vazio = (f == 4) && (fase_cnt >= cur_dv);
      if (bus.start_centrifugacao) sc_cnt++;
      else sc_cnt = 0;
      bus.centrifugacao_ativa = !stuck && sc_cnt >= 2 && sc_cnt <= 6;
      ativa_cyc += int'(bus.centrifugacao_ativa);
    end
  endtask

  task automatic espera_fase(input string nome, input int f, input int lim);
    int n = 0;
    while (int'(bus.fase) != f && n < lim) begin
      ciclo();
      n++;
    end
    check(nome, int'(bus.fase), f);
  endtask

  // Expected (phase, length) list from sensor delays; len 0 marks a terminal phase
  task automatic monta_modelo();
    bit fim = 0;
    exp_code.delete(); exp_len.delete();
    exp_motor = 0; exp_concl = 0; exp_erro = 0;
    for (int p = 0; p <= NE && !fim; p++) begin
      if (d_fill[p] >= TN - 1) begin
        exp_code.push_back(1); exp_len.push_back(TN);
        exp_code.push_back(7); exp_len.push_back(0);
        fim = 1; exp_erro = 1;
      end else begin
        exp_code.push_back(1); exp_len.push_back(d_fill[p] + 1);
        exp_code.push_back(p == 0 ? 2 : 3); exp_len.push_back(p == 0 ? TL : TE);
        exp_motor += (p == 0) ? TL : TE;
        if (d_drain[p] >= TN - 1) begin
          exp_code.push_back(4); exp_len.push_back(TN);
          exp_code.push_back(7); exp_len.push_back(0);
          fim = 1; exp_erro = 1;
        end else begin
          exp_code.push_back(4); exp_len.push_back(d_drain[p] + 1);
        end
      end
    end
    if (!fim) begin
      if (stuck) begin
        exp_code.push_back(5); exp_len.push_back(TC);
        exp_code.push_back(7); exp_len.push_back(0);
        exp_erro = 1;
      end else begin
        exp_code.push_back(5); exp_len.push_back(SpinLen);
        exp_code.push_back(0); exp_len.push_back(0);
        exp_concl = 1;
      end
    end
  endtask

  // Full run from a start pulse, compared phase by phase against the model
  task automatic executa(input string nome);
    int  obs_code[$];
    int  obs_len[$];
    int  cur, len, n;
    bit  terminou;
    monta_modelo();
    motor_cyc = 0; concl_cnt = 0;
    bus.start = 1; ciclo(); bus.start = 0;
    cur = int'(bus.fase); len = 1; terminou = 0; n = 0;
    while (!terminou && n < 3000) begin
      ciclo();
      n++;
      if (int'(bus.fase) == cur) begin
        len++;
      end else begin
        obs_code.push_back(cur); obs_len.push_back(len);
        cur = int'(bus.fase); len = 1;
        if (cur == 0 || cur == 7) begin
          terminou = 1;
          obs_code.push_back(cur); obs_len.push_back(0);
        end
      end
    end
    check({nome, ":terminou"}, int'(terminou), 1);
    check({nome, ":n_fases"}, obs_code.size(), exp_code.size());
    for (int i = 0; i < exp_code.size(); i++) begin
      if (i < obs_code.size()) begin
        check($sformatf("%s:fase[%0d]", nome, i), obs_code[i], exp_code[i]);
        if (exp_len[i] != 0)
          check($sformatf("%s:dur[%0d]", nome, i), obs_len[i], exp_len[i]);
      end
    end
    check({nome, ":motor"}, motor_cyc, exp_motor);
    check({nome, ":concluido"}, concl_cnt, exp_concl);
    check({nome, ":erro"}, int'(bus.erro), exp_erro);
  endtask

  function automatic int rnd_d();
    return ($urandom_range(0, 7) == 0) ? 200 : int'($urandom_range(0, 12));
  endfunction

  initial begin
    tab[0]  = '{1'b0, 1'b0, 1'b0, 9'b000_000000};
    tab[1]  = '{1'b1, 1'b1, 1'b0, 9'b000_000000};  // door open: start ignored
    tab[2]  = '{1'b1, 1'b0, 1'b0, 9'b000_000000};  // start held, no edge
    tab[3]  = '{1'b0, 1'b0, 1'b0, 9'b000_000000};
    tab[4]  = '{1'b1, 1'b0, 1'b0, 9'b001_100000};
    tab[5]  = '{1'b0, 1'b0, 1'b0, 9'b001_100000};
    tab[6]  = '{1'b0, 1'b0, 1'b1, 9'b010_010000};
    tab[7]  = '{1'b0, 1'b0, 1'b1, 9'b010_010000};
    tab[8]  = '{1'b0, 1'b1, 1'b0, 9'b110_000000};
    tab[9]  = '{1'b1, 1'b1, 1'b0, 9'b110_000000};
    tab[10] = '{1'b1, 1'b0, 1'b0, 9'b110_000000};
    tab[11] = '{1'b0, 1'b0, 1'b0, 9'b110_000000};
    tab[12] = '{1'b1, 1'b0, 1'b0, 9'b010_010000};
    tab[13] = '{1'b0, 1'b1, 1'b0, 9'b110_000000};

    plant_on = 0;
    atrasos(3, 3, 0);
    reinicia();
    check("reset_saidas", int'(saidas()), 0);

    for (int i = 0; i < 14; i++) begin
      bus.start = tab[i].start;
      bus.porta_aberta = tab[i].porta;
      bus.nivel_cheio = tab[i].cheio;
      ciclo();
      check($sformatf("tabela[%0d]", i), int'(saidas()), int'(tab[i].saida));
    end

    plant_on = 1;
    reinicia();
    atrasos(3, 3, 0);
    executa("nominal");

    reinicia();
    atrasos(3, 3, 0);
    d_fill[0] = 200;
    executa("timeout_encher");
    check("timeout_encher:valvula", int'(bus.valvula_entrada), 0);
    bus.start = 1; ciclo(); bus.start = 0; ciclo();
    check("timeout_encher:start_ignorado", int'(bus.fase), 7);

    reinicia();
    atrasos(3, 3, 1);
    executa("timeout_centrif");

    // Pause 8 cycles into the wash, then resume for the remaining 12
    reinicia();
    atrasos(3, 3, 0);
    motor_cyc = 0;
    bus.start = 1; ciclo(); bus.start = 0;
    espera_fase("pausa_lavar:entra", 2, 100);
    repeat (7) ciclo();
    bus.porta_aberta = 1; ciclo();
    check("pausa_lavar:fase", int'(bus.fase), 6);
    check("pausa_lavar:motor", int'(bus.motor_lavar), 0);
    bus.start = 1; ciclo(); bus.start = 0;
    check("pausa_lavar:porta_aberta", int'(bus.fase), 6);
    bus.porta_aberta = 0; ciclo();
    bus.start = 1; ciclo(); bus.start = 0;
    check("pausa_lavar:retoma", int'(bus.fase), 2);
    for (int n = 0; n < 40 && bus.fase == 3'd2; n++) ciclo();
    check("pausa_lavar:motor_total", motor_cyc, TL);
    check("pausa_lavar:esvaziar", int'(bus.fase), 4);

    // Pause mid-spin: spin restarts and the full burst is seen
    reinicia();
    atrasos(3, 3, 0);
    bus.start = 1; ciclo(); bus.start = 0;
    espera_fase("pausa_centrif:entra", 5, 400);
    repeat (3) ciclo();
    bus.porta_aberta = 1; ciclo();
    check("pausa_centrif:fase", int'(bus.fase), 6);
    check("pausa_centrif:start_centrif", int'(bus.start_centrifugacao), 0);
    bus.porta_aberta = 0; ciclo();
    ativa_cyc = 0; concl_cnt = 0;
    bus.start = 1; ciclo(); bus.start = 0;
    check("pausa_centrif:retoma", int'(bus.fase), 5);
    for (int n = 0; n < 50 && bus.fase == 3'd5; n++) ciclo();
    check("pausa_centrif:ativa", ativa_cyc, 5);
    check("pausa_centrif:concluido", concl_cnt, 1);
    check("pausa_centrif:fim", int'(bus.fase), 0);

    // Asynchronous reset between edges during the drain
    reinicia();
    atrasos(3, 3, 0);
    bus.start = 1; ciclo(); bus.start = 0;
    espera_fase("reset_async:esvaziar", 4, 100);
    #3;
    reset_n = 1'b0;
    #1;
    check("reset_async:saidas", int'(saidas()), 0);
    limpa();
    @(negedge clock);
    reset_n = 1'b1;
    executa("apos_reset");

    for (int r = 0; r < 6; r++) begin
      reinicia();
      for (int i = 0; i < 8; i++) begin
        d_fill[i] = rnd_d();
        d_drain[i] = rnd_d();
      end
      stuck = ($urandom_range(0, 5) == 0);
      executa($sformatf("aleatorio%0d", r));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/controlador_lavagem.md
Name: controlador_lavagem

Overview:
Top-level wash-cycle sequencer for the washing machine. It drives the inlet valve, wash motor and drain pump, and starts the spin module (module centrifugacao; its ports are start, centrifugacao_ativa and clock). The sequence is fill → wash → drain, then NUM_ENXAGUES × (fill → rinse → drain), then spin. It handles door-open pause, fill/drain timeouts and completion signalling.

Parameters:
TEMPO_LAVAGEM, 20, wash agitation length in clock cycles (≥1)
TEMPO_ENXAGUE, 10, rinse agitation length in clock cycles (≥1)
NUM_ENXAGUES, 2, rinse repetitions (1..7)
TIMEOUT_NIVEL, 50, max cycles allowed in a fill or drain phase before error (≥2)
TIMEOUT_CENTRIF, 15, max cycles allowed in spin before error; must exceed the spin module's TEMPO_CENTRIFUGACAO+2

Ports:
clock  input  1  system clock, rising edge
reset_n  input  1  asynchronous active-low reset
start  input  1  start/resume request, sampled as a rising edge
porta_aberta  input  1  door-open sensor, level
nivel_cheio  input  1  water-full sensor, level
nivel_vazio  input  1  water-empty sensor, level
centrifugacao_ativa  input  1  status from the spin module
valvula_entrada  output  1  inlet valve on
motor_lavar  output  1  agitation motor on
bomba_saida  output  1  drain pump on
start_centrifugacao  output  1  held high for the whole spin phase; drives the spin module's start
fase  output  3  current state code
concluido  output  1  one-cycle pulse at cycle completion
erro  output  1  sticky error flag

Behaviour:
- One clock domain: clock. reset_n is asynchronous, active-low.
- Reset state: OCIOSO. All outputs 0, timers 0, rinse counter 0, saved state OCIOSO.
- start_edge is start high while the previous sampled start was low. This is registered edge detection.
- State codes: OCIOSO=0, ENCHER=1, LAVAR=2, ENXAGUAR=3, ESVAZIAR=4, CENTRIFUGAR=5, PAUSA=6, ERRO=7. fase is registered and equals the current state.
- Outputs are decoded from the registered state (Moore):
  - valvula_entrada = ENCHER
  - motor_lavar = LAVAR or ENXAGUAR
  - bomba_saida = ESVAZIAR
  - start_centrifugacao = CENTRIFUGAR
  - erro = ERRO
- A single 16-bit phase timer clears on every state entry and increments each cycle while in the state.
- OCIOSO: on start_edge with porta_aberta=0, go to ENCHER and clear the rinse counter. A start_edge while the door is open is ignored.
- ENCHER:
  - nivel_cheio=1 → LAVAR if the rinse counter is 0, else ENXAGUAR.
  - Timer reaching TIMEOUT_NIVEL-1 without nivel_cheio → ERRO.
- LAVAR: exactly TEMPO_LAVAGEM cycles, then ESVAZIAR.
- ENXAGUAR: exactly TEMPO_ENXAGUE cycles, then ESVAZIAR.
- ESVAZIAR:
  - On nivel_vazio=1, if the rinse counter < NUM_ENXAGUES: increment the counter, go to ENCHER.
  - Otherwise go to CENTRIFUGAR.
  - Timer reaching TIMEOUT_NIVEL-1 without nivel_vazio → ERRO.
- CENTRIFUGAR:
  - A flag records that centrifugacao_ativa has been seen high.
  - When the flag is set and centrifugacao_ativa is low → OCIOSO, with concluido=1 for exactly that transition cycle. This is a registered pulse, visible the cycle OCIOSO is entered.
  - Timer reaching TIMEOUT_CENTRIF-1 → ERRO.
- Door open while in ENCHER, LAVAR, ENXAGUAR, ESVAZIAR or CENTRIFUGAR:
  - Next state is PAUSA and the current state is saved.
  - The phase timer and rinse counter freeze. All actuator outputs are 0 while in PAUSA.
- PAUSA: on start_edge with the door closed, return to the saved state.
  - The timer resumes from its frozen value, except after CENTRIFUGAR.
  - Resuming CENTRIFUGAR clears the timer and the seen-active flag. Dropping start_centrifugacao resets the spin module's counter, so the spin restarts from the beginning.
  - A start_edge while the door is still open is ignored.
- ERRO: all actuators 0, erro=1. Exit only via reset_n.
- Priority within one cycle:
  1. Door open (pause)
  2. Timeout
  3. Sensor/timer completion
- Sensors that are already satisfied on entry complete the phase after 1 cycle in state. Both sensors high is not checked; each phase looks only at its own sensor.
- Asserting reset_n low mid-operation forces OCIOSO and zeroes outputs immediately.

Test Plan:
- Nominal run, defaults, door closed: start pulse. nivel_cheio rises 3 cycles into each fill and nivel_vazio 3 cycles into each drain; spin model ativa high 5 cycles. Required: fase sequence 1,2,4,1,3,4,1,3,4,5,0; motor_lavar high exactly 20 cycles then 10 per rinse; one concluido pulse; erro=0.
- Fill timeout: start, nivel_cheio held 0 → fase=7 and erro=1 exactly 50 cycles after entering ENCHER; valve 0 afterwards; start ignored until reset.
- Pause in wash: door opens 8 cycles into LAVAR → next cycle fase=6, motor 0. Close door and pulse start → fase=2; the motor runs the remaining 12 cycles (20 total).
- Pause in spin: door opens mid-spin → start_centrifugacao drops. Resume → full 5-cycle ativa burst seen, then concluido.
- Spin timeout: ativa stuck at 0 → ERRO after 15 cycles in CENTRIFUGAR.
- Async reset asserted during ESVAZIAR, off clock edge → all outputs 0 and fase=0 before the next edge; a subsequent start runs the full cycle.
